// File: rtl/mem_pkg.sv
// Shared types and helpers for the burst memory: controller state encoding
// and the byte-address to word-index conversion.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } state_t;

  // Byte address -> word index, folded into the array depth.
  function automatic int unsigned word_index(input logic [63:0] byte_addr,
                                             input int unsigned bytes_per_word,
                                             input int unsigned depth);
    logic [63:0] w;
    w = byte_addr >> $clog2(bytes_per_word);
    return 32'(w % 64'(depth));
  endfunction

endpackage

// File: rtl/burst_addr_gen.sv
// Beat address generator shared by the read and write paths.
// Loads the start index on command accept (beat 0 uses the start index
// directly), then produces one new index per step. Linear increments wrap
// modulo DEPTH. With BURST_MEMORY_WRAP_EN defined, bursts whose beat count is
// a power of two wrap inside their aligned block instead.
module burst_addr_gen #(
  parameter int IDX_W          = 21,
  parameter int DEPTH          = 2097152,
  parameter int BURSTLEN_WIDTH = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      load,
  input  logic                      step,
  input  logic [IDX_W-1:0]          start_idx,
  input  logic [BURSTLEN_WIDTH-1:0] burst_len,
  output logic [IDX_W-1:0]          beat_idx,
  output logic                      last_beat
);

  logic [IDX_W-1:0]          addr_q, addr_d;
  logic [BURSTLEN_WIDTH-1:0] remain_q, remain_d;
  logic [IDX_W-1:0]          mask_q, mask_d;
  logic                      wrap_q, wrap_d;
  logic                      wrap_load;

  // Index of the beat after cur: block wrap when enabled, else linear mod DEPTH.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] cur,
                                                input logic [IDX_W-1:0] mask,
                                                input logic             wrap);
    logic [IDX_W-1:0] inc;
    inc = cur + IDX_W'(1);
    if (wrap) return (cur & ~mask) | (inc & mask);
    if (cur == IDX_W'(DEPTH - 1)) return '0;
    return inc;
  endfunction

`ifdef BURST_MEMORY_WRAP_EN
  logic [BURSTLEN_WIDTH:0] len_ext;
  // A burst wraps when its beat count (len+1) is a power of two.
  always_comb begin
    len_ext   = {1'b0, burst_len};
    wrap_load = ((len_ext + (BURSTLEN_WIDTH+1)'(1)) & len_ext) == '0;
  end
`else
  assign wrap_load = 1'b0;
`endif

  // Next-state of the beat address, remaining-beat counter and wrap setup.
  always_comb begin
    addr_d   = addr_q;
    remain_d = remain_q;
    mask_d   = mask_q;
    wrap_d   = wrap_q;
    if (load) begin
      addr_d   = next_idx(start_idx, IDX_W'(burst_len), wrap_load);
      remain_d = burst_len;
      mask_d   = IDX_W'(burst_len);
      wrap_d   = wrap_load;
    end else if (step) begin
      addr_d   = next_idx(addr_q, mask_q, wrap_q);
      remain_d = remain_q - BURSTLEN_WIDTH'(1);
    end
  end

  // Generator registers, cleared by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= '0;
      remain_q <= '0;
      mask_q   <= '0;
      wrap_q   <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      remain_q <= remain_d;
      mask_q   <= mask_d;
      wrap_q   <= wrap_d;
    end
  end

  assign beat_idx  = load ? start_idx : addr_q;
  assign last_beat = (remain_q == BURSTLEN_WIDTH'(1));

endmodule

// File: rtl/burst_memory.sv
// Burst-capable word memory with a single command port.
// Handshake: a command (rd or wr with addr/burst_len) is taken on a rising
// edge only while the controller is IDLE and waitrequest is low; waitrequest
// is high only during read bursts. Write beats after the first are taken on
// any WR_BURST cycle with wr high. rd_valid marks each returned read beat; no
// backpressure exists on the read return path.
// Optional macro BURST_MEMORY_WRAP_EN enables block-wrapping bursts.
module burst_memory
  import mem_pkg::*;
#(
  parameter int    ADDR_WIDTH     = 32,
  parameter int    DATA_WIDTH     = 32,
  parameter int    BURSTLEN_WIDTH = 4,
  parameter int    DEPTH          = 2097152,
  parameter string MEM_FILE       = "",
  parameter int    RD_LATENCY     = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [BURSTLEN_WIDTH-1:0] burst_len,
  input  logic [DATA_WIDTH/8-1:0]   byteenable,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic                      wr,
  input  logic                      rd,
  output logic                      waitrequest,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_valid
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t                state_q, state_d;
  logic                  rd_accept, wr_accept;
  logic                  rd_issue, wr_issue;
  logic                  load, step, last_beat;
  logic [IDX_W-1:0]      start_idx, beat_idx;

  logic [DATA_WIDTH-1:0] mem_array [DEPTH];

  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [DATA_WIDTH-1:0] dat_q [RD_LATENCY];
  logic [DATA_WIDTH-1:0] dat_d [RD_LATENCY];

  assign start_idx = IDX_W'(word_index(64'(addr), BYTES, DEPTH));
  assign load      = rd_accept | wr_accept;

  burst_addr_gen #(
    .IDX_W          (IDX_W),
    .DEPTH          (DEPTH),
    .BURSTLEN_WIDTH (BURSTLEN_WIDTH)
  ) u_addr_gen (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (load),
    .step      (step),
    .start_idx (start_idx),
    .burst_len (burst_len),
    .beat_idx  (beat_idx),
    .last_beat (last_beat)
  );

  // Controller: command accept, beat issue strobes and next state.
  always_comb begin
    state_d     = state_q;
    waitrequest = 1'b0;
    rd_accept   = 1'b0;
    wr_accept   = 1'b0;
    rd_issue    = 1'b0;
    wr_issue    = 1'b0;
    step        = 1'b0;
    case (state_q)
      IDLE: begin
        // Write wins a simultaneous request; the reader keeps rd asserted.
        wr_accept = wr;
        rd_accept = rd & ~wr;
        rd_issue  = rd_accept;
        wr_issue  = wr_accept;
        if (wr_accept && burst_len != '0)      state_d = WR_BURST;
        else if (rd_accept && burst_len != '0) state_d = RD_BURST;
      end
      RD_BURST: begin
        waitrequest = 1'b1;
        step        = 1'b1;
        rd_issue    = 1'b1;
        if (last_beat) state_d = IDLE;
      end
      WR_BURST: begin
        // wr low stalls the burst; position is held by the generator.
        if (wr) begin
          step     = 1'b1;
          wr_issue = 1'b1;
          if (last_beat) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Array: byte-masked writes; contents retained across reset.
  always_ff @(posedge clock) begin
    if (reset_n && wr_issue) begin
      for (int b = 0; b < BYTES; b++) begin
        if (byteenable[b]) mem_array[beat_idx][b*8 +: 8] <= data_in[b*8 +: 8];
      end
    end
  end

  // Read pipeline: data sampled at issue, each stage only loads on a valid
  // beat so the last stage holds the most recent returned word.
  always_comb begin
    vld_d[0] = rd_issue;
    dat_d[0] = rd_issue ? mem_array[beat_idx] : dat_q[0];
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
    end
  end

  // Read pipeline registers; reset drops any in-flight beats.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < RD_LATENCY; i++) dat_q[i] <= dat_d[i];
    end
  end

  assign rd_valid = vld_q[RD_LATENCY-1];
  assign rd_data  = dat_q[RD_LATENCY-1];

endmodule

// File: tb/tb_burst_memory.sv
// Directed bench for burst_memory: write/read bursts, stalls, byte enables,
// address wrap, write priority and reset during a read burst.
`timescale 1ns/1ps
module tb_burst_memory;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BLW   = 4;
  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] addr       = '0;
  logic [BLW-1:0] burst_len = '0;
  logic [3:0]    byteenable = '0;
  logic [DW-1:0] data_in    = '0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic          waitrequest;
  logic [DW-1:0] rd_data;
  logic          rd_valid;

  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;
  logic [DW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic [DW-1:0] mon_e;
  int            mon_ec;
  logic [DW-1:0] v [4];

  burst_memory #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .BURSTLEN_WIDTH (BLW),
    .DEPTH          (DEPTH),
    .MEM_FILE       (""),
    .RD_LATENCY     (LAT)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .addr        (addr),
    .burst_len   (burst_len),
    .byteenable  (byteenable),
    .data_in     (data_in),
    .wr          (wr),
    .rd          (rd),
    .waitrequest (waitrequest),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid)
  );

  // Clock and cycle counter
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitor: every returned beat must match the queue head in
  // both value and cycle.
  always @(negedge clock) begin
    if (reset_n && rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rd_valid: got data %h at cycle %0d, expected no beat", rd_data, cyc);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_ec = exp_cyc_q.pop_front();
        check("rd_data", rd_data, mon_e);
        check("rd_cycle", 32'(cyc), 32'(mon_ec));
      end
    end
  end

  // Issue a read burst; pushes beat k expected at accept cycle + LAT + k.
  task automatic do_read(input logic [AW-1:0] a, input int len, input logic [DW-1:0] d [4]);
    int t;
    int tries;
    addr      = a;
    burst_len = BLW'(len);
    rd        = 1'b1;
    wr        = 1'b0;
    tries     = 0;
    @(negedge clock);
    while (waitrequest && tries < 20) begin
      @(posedge clock); #1;
      @(negedge clock);
      tries++;
    end
    check("waitrequest_rd_accept", DW'(waitrequest), '0);
    t = cyc;
    for (int k = 0; k <= len; k++) begin
      exp_q.push_back(d[k]);
      exp_cyc_q.push_back(t + LAT + k);
    end
    @(posedge clock); #1;
    rd        = 1'b0;
    addr      = 32'hFFFF_FFF0;
    burst_len = '0;
    for (int k = 1; k <= len; k++) begin
      @(negedge clock);
      check("waitrequest_rd_burst", DW'(waitrequest), DW'(1));
      @(posedge clock); #1;
    end
  endtask

  // Issue a write burst; optional stall of stall_cycles before beat stall_beat
  // with rd held high during the stall.
  task automatic do_write(input logic [AW-1:0] a, input int len, input logic [DW-1:0] d [4],
                          input logic [3:0] be, input int stall_beat, input int stall_cycles,
                          input logic rd_too);
    addr       = a;
    burst_len  = BLW'(len);
    wr         = 1'b1;
    rd         = rd_too;
    data_in    = d[0];
    byteenable = be;
    @(negedge clock);
    check("waitrequest_wr_accept", DW'(waitrequest), '0);
    @(posedge clock); #1;
    rd        = 1'b0;
    addr      = 32'hFFFF_FFF0;
    burst_len = '0;
    for (int k = 1; k <= len; k++) begin
      if (k == stall_beat) begin
        wr = 1'b0;
        rd = 1'b1;
        for (int s = 0; s < stall_cycles; s++) begin
          @(negedge clock);
          check("waitrequest_wr_stall", DW'(waitrequest), '0);
          @(posedge clock); #1;
        end
        rd = 1'b0;
      end
      wr      = 1'b1;
      data_in = d[k];
      @(posedge clock); #1;
    end
    wr = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    check(name, DW'(exp_q.size()), '0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_rd_valid", DW'(rd_valid), '0);
    check("reset_rd_data", rd_data, '0);
    check("reset_waitrequest", DW'(waitrequest), '0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Fill words 0..11
    v = '{32'hA0A00000, 32'hA0A00001, 32'hA0A00002, 32'hA0A00003};
    do_write(32'h0, 3, v, 4'hF, 0, 0, 1'b0);
    v = '{32'hDEADBEEF, 32'h11223344, 32'hA0A00006, 32'hA0A00007};
    do_write(32'h10, 3, v, 4'hF, 0, 0, 1'b0);
    v = '{32'hA0A00008, 32'hA0A00009, 32'hA0A0000A, 32'hA0A0000B};
    do_write(32'h20, 3, v, 4'hF, 2, 2, 1'b0);

    // Single read, 4-beat read, stalled-write readback (back-to-back)
    v = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
    do_read(32'h10, 0, v);
    v = '{32'hA0A00000, 32'hA0A00001, 32'hA0A00002, 32'hA0A00003};
    do_read(32'h0, 3, v);
    v = '{32'hA0A00008, 32'hA0A00009, 32'hA0A0000A, 32'hA0A0000B};
    do_read(32'h20, 3, v);

    // Byte-enable merge on word 5
    v = '{32'hAABBCCDD, 32'h0, 32'h0, 32'h0};
    do_write(32'h14, 0, v, 4'b0101, 0, 0, 1'b0);
    v = '{32'h11BB33DD, 32'h0, 32'h0, 32'h0};
    do_read(32'h14, 0, v);

    // Burst from word 6: block wrap or linear
`ifdef BURST_MEMORY_WRAP_EN
    v = '{32'hA0A00006, 32'hA0A00007, 32'hDEADBEEF, 32'h11BB33DD};
`else
    v = '{32'hA0A00006, 32'hA0A00007, 32'hA0A00008, 32'hA0A00009};
`endif
    do_read(32'h18, 3, v);

    // Linear wrap past the top of the array: words 63, 0, 1
    v = '{32'hC0DE003F, 32'hC0DE0000, 32'hC0DE0001, 32'h0};
    do_write(32'hFC, 2, v, 4'hF, 0, 0, 1'b0);
    do_read(32'hFC, 2, v);
    v = '{32'hC0DE0000, 32'h0, 32'h0, 32'h0};
    do_read(32'h100, 0, v);

    // Write and read requested together: write wins, no read beat returned
    v = '{32'h5A5A5A5A, 32'h0, 32'h0, 32'h0};
    do_write(32'h30, 0, v, 4'hF, 0, 0, 1'b1);
    do_read(32'h30, 0, v);
    drain("drain_before_hold");

    // rd_data holds the last returned word while idle
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("idle_rd_valid", DW'(rd_valid), '0);
    check("rd_data_hold", rd_data, 32'h5A5A5A5A);
    @(posedge clock); #1;

    // Reset during beat 2 of a 4-beat read
    v = '{32'hC0DE0000, 32'hC0DE0001, 32'hA0A00002, 32'hA0A00003};
    do_read(32'h0, 3, v);
    check("beat2_rd_valid", DW'(rd_valid), DW'(1));
    reset_n = 1'b0;
    #1;
    check("async_reset_rd_valid", DW'(rd_valid), '0);
    check("async_reset_rd_data", rd_data, '0);
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    check("post_reset_waitrequest", DW'(waitrequest), '0);
    check("post_reset_rd_valid", DW'(rd_valid), '0);
    v = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
    do_read(32'h10, 0, v);
    drain("final_drain");

    repeat (3) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/burst_memory.md
BURST_MEMORY -- requirements
Module: burst_memory

Interface
REQ-001 Parameter ADDR_WIDTH, 32, byte address width.
REQ-002 Parameter DATA_WIDTH, 32, data width in bits; SHALL be a multiple of 8.
REQ-003 Parameter BURSTLEN_WIDTH, 4, burst length field width.
REQ-004 Parameter DEPTH, 2097152, memory size in words.
REQ-005 Parameter MEM_FILE, "", hex init file; empty means no load.
REQ-006 Parameter RD_LATENCY, 2, cycles from read acceptance to first rd_valid; SHALL be >= 1.
REQ-007 clock  input  1  clock, rising edge.
REQ-008 reset_n  input  1  reset, asynchronous, active-low.
REQ-009 addr  input  ADDR_WIDTH  byte address; word index = addr >> log2(DATA_WIDTH/8), modulo DEPTH.
REQ-010 burst_len  input  BURSTLEN_WIDTH  beats minus one (0 = single beat).
REQ-011 byteenable  input  DATA_WIDTH/8  per-byte write mask.
REQ-012 data_in  input  DATA_WIDTH  write data.
REQ-013 wr  input  1  write request/beat.
REQ-014 rd  input  1  read request.
REQ-015 waitrequest  output  1  command not accepted this cycle.
REQ-016 rd_data  output  DATA_WIDTH  read data.
REQ-017 rd_valid  output  1  rd_data valid this cycle.

Function
REQ-018 FSM states IDLE, RD_BURST, WR_BURST; commands (addr, burst_len, rd/wr) accepted only in IDLE with waitrequest low.
REQ-019 waitrequest SHALL be low in IDLE and WR_BURST, high in RD_BURST.
REQ-020 IDLE with wr and rd both high: write wins; rd ignored, requester holds it.
REQ-021 Read accept: latch address and count; issue one word read per cycle, accept cycle being beat 0; burst_len=0 stays in IDLE, else go RD_BURST and return to IDLE the cycle the last beat issues.
REQ-022 Beat k of a read accepted in cycle T SHALL appear with rd_valid high in cycle T+RD_LATENCY+k; burst_len+1 consecutive valid beats, no gaps.
REQ-023 Read data SHALL be sampled from the array at issue; reads pipelined RD_LATENCY deep, so back-to-back read bursts SHALL produce contiguous rd_valid streams.
REQ-024 Write accept: beat 0 written at accept edge; burst_len>0 moves to WR_BURST; each later cycle with wr high writes next beat; wr low stalls without losing position; return to IDLE after final beat.
REQ-025 Writes update only bytes with byteenable set; other bytes unchanged.
REQ-026 rd in WR_BURST SHALL be ignored.
REQ-027 Linear address increment SHALL wrap modulo DEPTH.
REQ-028 rd_data SHALL hold last valid value when rd_valid is low.

Reset
REQ-029 Asynchronous assertion: state IDLE, rd_valid 0, rd_data 0, read pipeline cleared, counters 0; in-flight bursts abort with no further rd_valid.
REQ-030 On reset assertion with MEM_FILE non-empty, array reloaded from MEM_FILE; otherwise contents retained.

Configuration
REQ-031 Macro BURST_MEMORY_WRAP_EN defined: when burst_len+1 is a power of two, beat addresses wrap within the aligned (burst_len+1)-word block containing the start address; otherwise linear.
REQ-032 BURST_MEMORY_WRAP_EN undefined: all bursts linear.

Structure
REQ-033 Package mem_pkg SHALL hold state_t enum (IDLE, RD_BURST, WR_BURST) and word-index helper function.
REQ-034 Sub-module burst_addr_gen SHALL own start-address load, beat counter, increment and wrap logic, shared by read and write paths.

Verification
REQ-035 Single read addr=0x10, burst_len=0, RD_LATENCY=2, word4=0xDEADBEEF -> rd_valid one cycle at T+2, rd_data=0xDEADBEEF.
REQ-036 Read burst addr=0x0, burst_len=3 -> rd_valid cycles T+2..T+5 with words 0..3; waitrequest high T+1..T+3.
REQ-037 Write burst addr=0x20, burst_len=3, wr low on beat 2 for 2 cycles -> words 8..11 written in order; readback matches.
REQ-038 Word 5=0x11223344, write 0xAABBCCDD byteenable=4'b0101 -> readback 0x11BB33DD.
REQ-039 WRAP_EN defined: read addr=0x18 (word 6), burst_len=3 -> words 6,7,4,5; undefined -> 6,7,8,9.
REQ-040 reset_n low during beat 2 of 4-beat read -> rd_valid 0 immediately, no further beats after release; next read correct.
